enc_bin2onehot_pipe: RTL and testbench

- Parametrised, registered successor of the combinational binary-to-one-hot encoder.
- Converts an IN_W-bit index to an OUT_W-bit one-hot or thermometer code.
- Valid/ready handshakes on both sides, with a 2-entry output skid buffer.
- Flags out-of-range indices and keeps a saturating count of them.
- Sits between a command decoder and downstream per-lane enable logic.

---
 rtl/enc_bin2onehot_pipe.sv | 126 ++++++++++++
 tb/tb_enc_bin2onehot_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/enc_bin2onehot_pipe.sv
// Registered binary-index to one-hot/thermometer encoder behind a 2-entry skid buffer.
// One-cycle latency from an accepted index to the buffer head; in_ready reflects occupancy only.
module enc_bin2onehot_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 15,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in,
  input  logic             in_mode,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out,
  output logic             out_oor,
  input  logic             out_ready,
  output logic [CNT_W-1:0] oor_cnt,
  input  logic             clear_cnt
);

  if (OUT_W < 1 || OUT_W > (2 ** IN_W)) begin : g_bad_out_w
    $error("enc_bin2onehot_pipe: OUT_W must lie in 1..2**IN_W");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OUT_W-1:0] code;
    logic             oor;
  } ent_t;

  state_t           state_q, state_d;
  ent_t             head_q, head_d;
  ent_t             tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [OUT_W-1:0] enc_code;
  logic             enc_oor;
  ent_t             enc_ent;
  logic             push, pop;

  // Indices at or beyond OUT_W have no lane; they encode to zero in both modes.
  always_comb begin
    enc_code = '0;
    enc_oor  = (int'(in) >= OUT_W);
    for (int k = 0; k < OUT_W; k++) begin
      enc_code[k] = in_mode ? (k <= int'(in)) : (k == int'(in));
    end
    if (enc_oor) begin
      enc_code = '0;
    end
  end

  assign enc_ent  = {enc_code, enc_oor};
  assign in_ready = (state_q != FULL) && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  assign out_valid = (state_q != EMPTY);
  assign out       = out_valid ? head_q.code : '0;
  assign out_oor   = out_valid ? head_q.oor : 1'b0;
  assign oor_cnt   = cnt_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = enc_ent;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && !pop) begin
          tail_d  = enc_ent;
          state_d = FULL;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          head_d  = enc_ent;
        end
      end
      FULL: begin
        // The second entry slides forward; no push can happen while full.
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_cnt) begin
      cnt_d = '0;
    end else if (push && enc_oor && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_enc_bin2onehot_pipe.sv
// Directed and random checks of enc_bin2onehot_pipe against a queue-based reference model.
module tb_enc_bin2onehot_pipe;

  localparam int IN_W  = 4;
  localparam int OUT_W = 15;
  localparam int CNT_W = 8;
  localparam int CMAX  = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [IN_W-1:0]  in_idx;
  logic             in_mode;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_code;
  logic             out_oor;
  logic             out_ready;
  logic [CNT_W-1:0] oor_cnt;
  logic             clear_cnt;

  enc_bin2onehot_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_idx), .in_mode(in_mode),
    .in_ready(in_ready), .out_valid(out_valid), .out(out_code), .out_oor(out_oor),
    .out_ready(out_ready), .oor_cnt(oor_cnt), .clear_cnt(clear_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] code;
    logic             oor;
  } ent_t;

  ent_t             mq[$];
  int               mcnt;
  logic [OUT_W-1:0] plog[$];
  int               total = 0;
  int               bad   = 0;

  function automatic ent_t ref_enc(int v, bit m);
    ent_t e;
    if (v >= OUT_W) begin
      e.code = '0;
      e.oor  = 1'b1;
    end else begin
      e.code = m ? OUT_W'((32'd1 << (v + 1)) - 1) : OUT_W'(32'd1 << v);
      e.oor  = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, then advance model and DUT by one clock.
  task automatic tick();
    bit push, pop;
    #1;
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out", 32'(out_code), 32'(mq[0].code));
      chk("out_oor", 32'(out_oor), 32'(mq[0].oor));
    end else begin
      chk("out_idle", 32'(out_code), 32'd0);
      chk("oor_idle", 32'(out_oor), 32'd0);
    end
    chk("oor_cnt", 32'(oor_cnt), 32'(mcnt));
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() > 0);
    if (pop) begin
      plog.push_back(mq[0].code);
      void'(mq.pop_front());
    end
    if (push) mq.push_back(ref_enc(int'(in_idx), in_mode));
    if (clear_cnt) mcnt = 0;
    else if (push && int'(in_idx) >= OUT_W && mcnt < CMAX) mcnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int idx, input bit m);
    in_valid = v;
    in_idx   = IN_W'(idx);
    in_mode  = m;
  endtask

  initial begin
    logic [OUT_W-1:0] seen;
    rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_mode = 1'b0;
    out_ready = 1'b1; clear_cnt = 1'b0; mcnt = 0;

    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out_code), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cnt", 32'(oor_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single one-hot push of 6
    drive(1, 6, 0); tick();
    drive(0, 0, 0);
    chk("p6_out", 32'(out_code), 32'h0040);
    chk("p6_vld", 32'(out_valid), 32'd1);
    tick();
    chk("p6_gone", 32'(out_valid), 32'd0);

    // One-hot sweep over every lane
    plog.delete();
    for (int i = 0; i < OUT_W; i++) begin drive(1, i, 0); tick(); end
    drive(0, 0, 0); tick(); tick();
    chk("sweep_n", 32'(plog.size()), 32'(OUT_W));
    seen = '0;
    for (int i = 0; i < plog.size(); i++) begin
      chk("sweep_bit", 32'(plog[i]), 32'd1 << i);
      seen |= plog[i];
    end
    chk("sweep_all", 32'(seen), 32'h7FFF);

    // Thermometer
    drive(1, 3, 1); tick(); drive(0, 0, 0);
    chk("th3", 32'(out_code), 32'h000F);
    drive(1, 14, 1); tick(); drive(0, 0, 0);
    chk("th14", 32'(out_code), 32'h7FFF);
    tick();

    // Out-of-range, saturation, clear priority
    drive(1, 15, 0); tick(); drive(0, 0, 0);
    chk("oor_code", 32'(out_code), 32'd0);
    chk("oor_flag", 32'(out_oor), 32'd1);
    chk("oor_cnt1", 32'(oor_cnt), 32'd1);
    for (int i = 0; i < 299; i++) begin drive(1, 15, i[0]); tick(); end
    drive(0, 0, 0); tick();
    chk("oor_sat", 32'(oor_cnt), 32'd255);
    drive(1, 15, 0); clear_cnt = 1'b1; tick();
    clear_cnt = 1'b0; drive(0, 0, 0);
    chk("oor_clr", 32'(oor_cnt), 32'd0);
    tick(); tick();

    // Backpressure: 2 and 5 accepted, 9 held upstream
    plog.delete();
    out_ready = 1'b0;
    drive(1, 2, 0); tick();
    drive(1, 5, 0); tick();
    drive(1, 9, 0); tick();
    chk("bp_full", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b1;
    tick(); tick(); drive(0, 0, 0); tick(); tick();
    chk("bp_n", 32'(plog.size()), 32'd3);
    if (plog.size() == 3) begin
      chk("bp_0", 32'(plog[0]), 32'h0004);
      chk("bp_1", 32'(plog[1]), 32'h0020);
      chk("bp_2", 32'(plog[2]), 32'h0200);
    end

    // Streaming at full rate
    for (int i = 0; i < 20; i++) begin
      drive(1, $urandom_range(0, 14), $urandom_range(0, 1));
      tick();
      chk("stream_rdy", 32'(in_ready), 32'd1);
      chk("stream_vld", 32'(out_valid), 32'd1);
    end
    drive(0, 0, 0); tick();

    // Asynchronous reset while full
    out_ready = 1'b0;
    drive(1, 15, 0); tick();
    drive(1, 7, 1); tick();
    drive(0, 0, 0);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_out", 32'(out_code), 32'd0);
    chk("arst_cnt", 32'(oor_cnt), 32'd0);
    chk("arst_rdy", 32'(in_ready), 32'd0);
    mq.delete(); mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    plog.delete();
    tick(); tick(); tick();
    chk("post_rst_stale", 32'(plog.size()), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      clear_cnt = ($urandom_range(0, 39) == 0);
      tick();
    end
    drive(0, 0, 0); clear_cnt = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
